// File: rtl/mips_pkg.sv
// Shared constants and next-PC select encoding for the fetch stage.
package mips_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  // PC_HOLD covers the stall case; the other five name the taken source.
  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_JR     = 3'd3,
    PC_EXC    = 3'd4,
    PC_HOLD   = 3'd5
  } pc_sel_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection and redirect target arithmetic.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_ADDR = EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [25:0] if_id_target,
  input  logic [31:0] if_id_pc_plus4,
  input  logic        if_id_valid,
  input  logic        stall,
  input  logic        exception,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic [31:2] id_jr_word,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output pc_sel_e     sel
);

  logic        ctrl_ok;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;

  // Control from ID only counts for a real instruction and never while stalled.
  assign ctrl_ok       = if_id_valid & ~stall;
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = if_id_pc_plus4 + branch_offset(if_id_target[15:0]);
  assign jump_target   = {if_id_pc_plus4[31:28], if_id_target, 2'b00};
  assign jr_target     = {id_jr_word, 2'b00};

  always_comb begin
    sel     = PC_SEQ;
    next_pc = pc_plus4;
    if (exception) begin
      sel     = PC_EXC;
      next_pc = {EXC_ADDR[31:2], 2'b00};
    end else if (stall) begin
      sel     = PC_HOLD;
      next_pc = pc;
    end else if (ctrl_ok && id_jr) begin
      sel     = PC_JR;
      next_pc = jr_target;
    end else if (ctrl_ok && id_jump) begin
      sel     = PC_JUMP;
      next_pc = jump_target;
    end else if (ctrl_ok && id_branch_taken) begin
      sel     = PC_BRANCH;
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IF/ID pipeline register and accepted-fetch counter.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exception,
  input  logic        id_branch_taken,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic [31:0] id_jr_addr,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [31:0]       next_pc;
  mips_pkg::pc_sel_e sel;

  assign Address = {pc[31:2], 2'b00};

  next_pc_sel #(
    .EXC_ADDR(EXC_VECTOR)
  ) u_next_pc_sel (
    .pc              (Address),
    .if_id_target    (if_id_instruction[25:0]),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .stall           (stall),
    .exception       (exception),
    .id_branch_taken (id_branch_taken),
    .id_jump         (id_jump),
    .id_jr           (id_jr),
    .id_jr_word      (id_jr_addr[31:2]),
    .pc_plus4        (pc_plus4),
    .next_pc         (next_pc),
    .sel             (sel)
  );

  // Any redirect squashes the wrong-path fetch, so there is no delay slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc                <= {RESET_PC[31:2], 2'b00};
      if_id_instruction <= 32'd0;
      if_id_pc_plus4    <= 32'd0;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'd0;
    end else begin
      case (sel)
        mips_pkg::PC_HOLD: begin
        end
        mips_pkg::PC_SEQ: begin
          pc                <= next_pc;
          if_id_instruction <= Instruction;
          if_id_pc_plus4    <= pc_plus4;
          if_id_valid       <= 1'b1;
          fetch_count       <= fetch_count + 32'd1;
        end
        default: begin
          pc                <= next_pc;
          if_id_instruction <= 32'd0;
          if_id_pc_plus4    <= 32'd0;
          if_id_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch against a spec-level reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exception;
  logic        id_branch_taken;
  logic        id_jump;
  logic        id_jr;
  logic [31:0] id_jr_addr;
  logic [31:0] instruction;
  logic [31:0] address;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] imem [256];

  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_pp4;
  logic        m_valid;
  logic [31:0] m_cnt;

  int errors;
  int checks;

  instruction_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .exception         (exception),
    .id_branch_taken   (id_branch_taken),
    .id_jump           (id_jump),
    .id_jr             (id_jr),
    .id_jr_addr        (id_jr_addr),
    .Instruction       (instruction),
    .Address           (address),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_count       (fetch_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = imem[address[9:2]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance the reference model, sample #1 after the edge.
  task automatic step(input logic r, input logic s, input logic e, input logic b,
                      input logic j, input logic jr_i, input logic [31:0] ja);
    int off;
    reset = r; stall = s; exception = e; id_branch_taken = b;
    id_jump = j; id_jr = jr_i; id_jr_addr = ja;
    if (r) begin
      m_pc = 32'h0; m_ins = 0; m_pp4 = 0; m_valid = 0; m_cnt = 0;
    end else if (e) begin
      m_pc = 32'h8000_0008; m_ins = 0; m_pp4 = 0; m_valid = 0;
    end else if (s) begin
      // hold everything
    end else if (m_valid && jr_i) begin
      m_pc = ja & ~32'd3; m_ins = 0; m_pp4 = 0; m_valid = 0;
    end else if (m_valid && j) begin
      m_pc = {m_pp4[31:28], m_ins[25:0], 2'b00}; m_ins = 0; m_pp4 = 0; m_valid = 0;
    end else if (m_valid && b) begin
      off  = int'($signed(m_ins[15:0])) * 4;
      m_pc = m_pp4 + 32'(off); m_ins = 0; m_pp4 = 0; m_valid = 0;
    end else begin
      m_ins   = imem[m_pc[9:2]];
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_address: got %h expected %h", address, 32'h0); end
    checks++; if (if_id_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", if_id_instruction); end
    checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pp4: got %h expected 0", if_id_pc_plus4); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
  endtask

  task automatic test_seq_fetch();
    imem[0] = 32'h2004_0003;
    do_reset();
    idle(1);
    checks++; if (if_id_instruction !== 32'h2004_0003) begin errors++; $display("FAIL seq_instr: got %h expected %h", if_id_instruction, 32'h2004_0003); end
    checks++; if (if_id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL seq_pp4: got %h expected 4", if_id_pc_plus4); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", if_id_valid); end
    checks++; if (address !== 32'h4) begin errors++; $display("FAIL seq_address: got %h expected 4", address); end
    checks++; if (fetch_count !== 32'h1) begin errors++; $display("FAIL seq_count: got %h expected 1", fetch_count); end
  endtask

  task automatic test_jump();
    imem[1] = 32'h0C00_0003;
    do_reset();
    idle(2);
    checks++; if (if_id_instruction !== 32'h0C00_0003 || if_id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL jump_setup: got %h/%h expected 0c000003/8", if_id_instruction, if_id_pc_plus4); end
    step(0, 0, 0, 0, 1, 0, 32'h0);
    checks++; if (address !== 32'hC) begin errors++; $display("FAIL jump_address: got %h expected c", address); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jump_bubble: got %b expected 0", if_id_valid); end
    checks++; if (fetch_count !== 32'h2) begin errors++; $display("FAIL jump_count: got %h expected 2", fetch_count); end
  endtask

  task automatic test_branch();
    imem[2] = 32'h1000_FFFF;
    do_reset();
    idle(3);
    step(0, 0, 0, 1, 0, 0, 32'h0);
    checks++; if (address !== 32'h8) begin errors++; $display("FAIL branch_address: got %h expected 8", address); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL branch_bubble: got %b/%h/%h expected 0/0/0", if_id_valid, if_id_instruction, if_id_pc_plus4); end
  endtask

  task automatic test_jr();
    do_reset();
    idle(1);
    step(0, 0, 0, 0, 0, 1, 32'h0000_002B);
    checks++; if (address !== 32'h28) begin errors++; $display("FAIL jr_address: got %h expected 28", address); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL jr_bubble: got %b expected 0", if_id_valid); end
    step(0, 0, 0, 0, 0, 1, 32'h0000_0100);
    checks++; if (address !== 32'h2C) begin errors++; $display("FAIL jr_needs_valid: got %h expected 2c", address); end
  endtask

  task automatic test_stall_exception();
    logic [31:0] a0, i0, p0, c0;
    do_reset();
    idle(2);
    a0 = address; i0 = if_id_instruction; p0 = if_id_pc_plus4; c0 = fetch_count;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1, 0, 32'h0);
      checks++; if (address !== 32'h8 || address !== a0) begin errors++; $display("FAIL stall_address[%0d]: got %h expected 8", i, address); end
      checks++; if (if_id_instruction !== i0 || if_id_pc_plus4 !== p0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b expected %h/%h/1", i, if_id_instruction, if_id_pc_plus4, if_id_valid, i0, p0); end
      checks++; if (fetch_count !== c0) begin errors++; $display("FAIL stall_count[%0d]: got %h expected %h", i, fetch_count, c0); end
    end
    step(0, 1, 1, 0, 1, 0, 32'h0);
    checks++; if (address !== 32'h8000_0008) begin errors++; $display("FAIL exc_address: got %h expected 80000008", address); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0) begin errors++; $display("FAIL exc_flush: got %b/%h expected 0/0", if_id_valid, if_id_instruction); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    idle(16);
    checks++; if (address !== 32'h40) begin errors++; $display("FAIL rst_stall_setup: got %h expected 40", address); end
    step(0, 1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 1, 0, 32'h0);
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL rst_stall_address: got %h expected 0", address); end
    checks++; if (if_id_instruction !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL rst_stall_clear: got %h/%h/%b/%h expected all 0", if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8, $urandom);
      checks++; if (address !== m_pc) begin errors++; $display("FAIL rand_address[%0d]: got %h expected %h", n, address, m_pc); end
      checks++; if (if_id_instruction !== m_ins) begin errors++; $display("FAIL rand_instr[%0d]: got %h expected %h", n, if_id_instruction, m_ins); end
      checks++; if (if_id_pc_plus4 !== m_pp4) begin errors++; $display("FAIL rand_pp4[%0d]: got %h expected %h", n, if_id_pc_plus4, m_pp4); end
      checks++; if (if_id_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, if_id_valid, m_valid); end
      checks++; if (fetch_count !== m_cnt) begin errors++; $display("FAIL rand_count[%0d]: got %h expected %h", n, fetch_count, m_cnt); end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1; stall = 0; exception = 0; id_branch_taken = 0;
    id_jump = 0; id_jr = 0; id_jr_addr = 0;
    m_pc = 0; m_ins = 0; m_pp4 = 0; m_valid = 0; m_cnt = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_seq_fetch();
    test_jump();
    test_branch();
    test_jr();
    test_stall_exception();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
